// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared constants, read-FSM state type and index helpers for the FFT reorder buffer.
package fft_bitrev_reorder_pkg;

  localparam int FFT_WIDTH = 32;
  localparam int FFT_N     = 64;
  localparam int MAX_LOG2N = 12;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_e;

  // Smallest exponent e with 2**e >= value; usable in localparam expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 16; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Reverses the low log2n bits of value; higher bits of the result are zero.
  function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] value,
                                                  input int log2n);
    logic [MAX_LOG2N-1:0] rev;
    rev = {<<{value}};
    return rev >> (MAX_LOG2N - log2n);
  endfunction

endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// Sample stream bundle between the FFT core, the reorder buffer and its consumer.
interface fft_bitrev_reorder_if #(
  parameter int WIDTH = fft_bitrev_reorder_pkg::FFT_WIDTH
);

  logic                    input_en;
  logic                    input_sof;
  logic signed [WIDTH-1:0] input_real;
  logic signed [WIDTH-1:0] input_imag;

  logic                    output_en;
  logic                    output_sof;
  logic                    output_eof;
  logic signed [WIDTH-1:0] output_real;
  logic signed [WIDTH-1:0] output_imag;

  // Upstream side: produces input samples, consumes the reordered stream.
  modport master (
    output input_en, input_sof, input_real, input_imag,
    input  output_en, output_sof, output_eof, output_real, output_imag
  );

  // Reorder buffer side.
  modport slave (
    input  input_en, input_sof, input_real, input_imag,
    output output_en, output_sof, output_eof, output_real, output_imag
  );

endinterface

// File: rtl/fft_bitrev_reorder_pp_ram.sv
// Ping-pong sample store: one write port, one registered read port.
// The address MSB selects the bank; no reset so it maps onto block RAM.
module fft_bitrev_reorder_pp_ram #(
  parameter int DEPTH  = 128,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 7
) (
  input  logic              clock,
  input  logic              wrEn_i,
  input  logic [ADDR_W-1:0] wrAddr_i,
  input  logic [DATA_W-1:0] wrData_i,
  input  logic              rdEn_i,
  input  logic [ADDR_W-1:0] rdAddr_i,
  output logic [DATA_W-1:0] rdData_o
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clock) begin
    if (wrEn_i) mem[wrAddr_i] <= wrData_i;
  end

  // Registered read port.
  always_ff @(posedge clock) begin
    if (rdEn_i) rdData_o <= mem[rdAddr_i];
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Streaming reorder buffer: turns bit-reversed FFT frames into natural-order bursts.
module fft_bitrev_reorder
  import fft_bitrev_reorder_pkg::*;
#(
  parameter int WIDTH  = FFT_WIDTH,
  parameter int N      = FFT_N,
  parameter int BITREV = 1
) (
  input  logic                clock,
  input  logic                reset,
  fft_bitrev_reorder_if.slave bus
);

  localparam int               LOG2N  = clog2(N);
  localparam int               ADDR_W = LOG2N + 1;
  localparam logic [LOG2N-1:0] LAST   = LOG2N'(N - 1);

  logic [LOG2N-1:0]   wrCnt_q, wrCnt_d;
  logic               wrBank_q, wrBank_d;
  logic [LOG2N-1:0]   wrAddrRev;
  logic [LOG2N-1:0]   wrAddr;
  logic               frameReady;

  rd_state_e          state_q, state_d;
  logic [LOG2N-1:0]   rdCnt_q, rdCnt_d;
  logic               rdBank_q, rdBank_d;
  logic               rdIssue, rdFirst, rdLast;
  logic [ADDR_W-1:0]  rdAddr;

  logic               s1Valid_q, s1Sof_q, s1Eof_q;
  logic [2*WIDTH-1:0] rdData;

  assign wrAddrRev = LOG2N'(bitrev(MAX_LOG2N'(wrCnt_q), LOG2N));

  // Write counter/bank update; a start-of-frame restarts the current bank at count 0.
  always_comb begin
    wrCnt_d    = wrCnt_q;
    wrBank_d   = wrBank_q;
    frameReady = 1'b0;
    wrAddr     = (BITREV != 0) ? wrAddrRev : wrCnt_q;
    if (bus.input_en) begin
      if (bus.input_sof) begin
        wrAddr  = '0;
        wrCnt_d = LOG2N'(1);
      end else if (wrCnt_q == LAST) begin
        wrCnt_d    = '0;
        wrBank_d   = ~wrBank_q;
        frameReady = 1'b1;
      end else begin
        wrCnt_d = wrCnt_q + 1'b1;
      end
    end
  end

  // Write-side state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrCnt_q  <= '0;
      wrBank_q <= 1'b0;
    end else begin
      wrCnt_q  <= wrCnt_d;
      wrBank_q <= wrBank_d;
    end
  end

  // Read FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= RD_IDLE;
      rdCnt_q  <= '0;
      rdBank_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdCnt_q  <= rdCnt_d;
      rdBank_q <= rdBank_d;
    end
  end

  // Read FSM next state; a frame completing on the final read chains straight into the next burst.
  always_comb begin
    state_d  = state_q;
    rdCnt_d  = rdCnt_q;
    rdBank_d = rdBank_q;
    case (state_q)
      RD_IDLE: begin
        if (frameReady) begin
          state_d  = RD_READ;
          rdCnt_d  = '0;
          rdBank_d = wrBank_q;
        end
      end
      RD_READ: begin
        rdCnt_d = rdCnt_q + 1'b1;
        if (rdCnt_q == LAST) begin
          rdCnt_d = '0;
          if (frameReady) rdBank_d = wrBank_q;
          else            state_d  = RD_IDLE;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  // Read FSM outputs: RAM read request and frame markers for the issued address.
  always_comb begin
    rdIssue = (state_q == RD_READ);
    rdFirst = rdIssue && (rdCnt_q == '0);
    rdLast  = rdIssue && (rdCnt_q == LAST);
    rdAddr  = {rdBank_q, rdCnt_q};
  end

  fft_bitrev_reorder_pp_ram #(
    .DEPTH  (2 * N),
    .DATA_W (2 * WIDTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock    (clock),
    .wrEn_i   (bus.input_en),
    .wrAddr_i ({wrBank_q, wrAddr}),
    .wrData_i ({bus.input_real, bus.input_imag}),
    .rdEn_i   (rdIssue),
    .rdAddr_i (rdAddr),
    .rdData_o (rdData)
  );

  // Markers travel alongside the RAM read latency.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1Valid_q <= 1'b0;
      s1Sof_q   <= 1'b0;
      s1Eof_q   <= 1'b0;
    end else begin
      s1Valid_q <= rdIssue;
      s1Sof_q   <= rdFirst;
      s1Eof_q   <= rdLast;
    end
  end

  // Output register; everything is forced to zero when no sample is valid.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.output_en   <= 1'b0;
      bus.output_sof  <= 1'b0;
      bus.output_eof  <= 1'b0;
      bus.output_real <= '0;
      bus.output_imag <= '0;
    end else begin
      bus.output_en   <= s1Valid_q;
      bus.output_sof  <= s1Valid_q & s1Sof_q;
      bus.output_eof  <= s1Valid_q & s1Eof_q;
      bus.output_real <= s1Valid_q ? rdData[2*WIDTH-1:WIDTH] : '0;
      bus.output_imag <= s1Valid_q ? rdData[WIDTH-1:0]       : '0;
    end
  end

endmodule
